dmem_cache: RTL

- Responder side of the CPU data-memory port: accepts the pipeline's load/store requests (address, read/write strobes, write data) and returns read data plus a stall.
- Fronts an internal word-addressed backing store with a direct-mapped, write-through, no-write-allocate cache.
- Misses and writes take multi-cycle latency; the CPU freezes PC and pipeline registers while stall is high and holds the request stable.

---
 rtl/dmem_cache.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dmem_cache.sv
// CPU data-memory responder: a direct-mapped, write-through, no-write-allocate cache
// (one word per line) in front of a word-addressed backing store.
module dmem_cache #(
    parameter int DEPTH     = 8,
    parameter int INDEX     = 4,
    parameter int MISS_LAT  = 4,
    parameter int WRITE_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall
);

    localparam int TAGW  = DEPTH - INDEX;
    localparam int LINES = 1 << INDEX;
    localparam int WORDS = 1 << DEPTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [3:0]       cnt;
    logic [DEPTH-1:0] lat_word;
    logic [31:0]      lat_wdata;

    logic [LINES-1:0] valid;
    logic [TAGW-1:0]  tag_arr  [LINES];
    logic [31:0]      data_arr [LINES];
    logic [31:0]      backing  [WORDS];

    logic [DEPTH-1:0] word_addr;
    logic [INDEX-1:0] idx;
    logic [TAGW-1:0]  tag;
    logic [INDEX-1:0] lat_idx;
    logic [TAGW-1:0]  lat_tag;
    logic             hit;
    logic             fill_done;
    logic             write_done;
    logic             unused_addr_bits;

    // Upper address bits wrap the word address modulo the backing-store size.
    assign word_addr        = addr[DEPTH+1:2];
    assign idx              = word_addr[INDEX-1:0];
    assign tag              = word_addr[DEPTH-1:INDEX];
    assign lat_idx          = lat_word[INDEX-1:0];
    assign lat_tag          = lat_word[DEPTH-1:INDEX];
    assign unused_addr_bits = ^{addr[31:DEPTH+2], addr[1:0]};

    assign hit        = valid[idx] && (tag_arr[idx] == tag);
    assign fill_done  = (state == S_FILL)  && (cnt == 4'd1);
    assign write_done = (state == S_WRITE) && (cnt == 4'd1);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        stall = 1'b0;
        rdata = '0;
        case (state)
            S_IDLE: begin
                stall = memwrite | (memread & ~hit);
                if (memread && !memwrite && hit) rdata = data_arr[idx];
            end
            S_FILL, S_WRITE: stall = 1'b1;
            default: stall = 1'b0;
        endcase
        // Outputs are forced quiet while reset is held, even if a request is present.
        if (!reset) begin
            stall = 1'b0;
            rdata = '0;
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_word  <= '0;
            lat_wdata <= '0;
            valid     <= '0;
            // NOTE: the backing store must power up zeroed, so it is reset here; tag/data
            // arrays are not, because a cleared valid bit already hides their contents.
            for (int i = 0; i < WORDS; i++) backing[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (memwrite) begin
                        lat_word  <= word_addr;
                        lat_wdata <= wdata;
                        cnt       <= 4'(WRITE_LAT);
                        state     <= S_WRITE;
                    end else if (memread && !hit) begin
                        lat_word <= word_addr;
                        cnt      <= 4'(MISS_LAT);
                        state    <= S_FILL;
                    end
                end
                S_FILL: begin
                    cnt <= cnt - 4'd1;
                    if (fill_done) begin
                        valid[lat_idx] <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    cnt <= cnt - 4'd1;
                    if (write_done) begin
                        backing[lat_word] <= lat_wdata;
                        state             <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Reset forces IDLE asynchronously, so neither enable can fire while reset is held.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_arr[lat_idx]  <= lat_tag;
            data_arr[lat_idx] <= backing[lat_word];
        end else if (write_done && valid[lat_idx] && (tag_arr[lat_idx] == lat_tag)) begin
            data_arr[lat_idx] <= lat_wdata;
        end
    end

endmodule
